// File: rtl/gate_lib_pkg.sv
// Shared gate-library package: mode encodings, the checker FSM state type
// and the golden reference gate used by self-test blocks.
package gate_lib_pkg;

    localparam int unsigned GL_MAX_IN = 16;

    localparam logic [2:0] GL_AND  = 3'd0;
    localparam logic [2:0] GL_OR   = 3'd1;
    localparam logic [2:0] GL_XOR  = 3'd2;
    localparam logic [2:0] GL_NAND = 3'd3;
    localparam logic [2:0] GL_NOR  = 3'd4;
    localparam logic [2:0] GL_XNOR = 3'd5;

    typedef enum logic [2:0] {
        GSC_IDLE,
        GSC_APPLY,
        GSC_WAIT,
        GSC_CHECK,
        GSC_DONE
    } gsc_state_t;

    // Reduction gate over the low n_in bits of vec. Reserved modes fall back to AND.
    function automatic logic golden_gate(input logic [2:0] mode,
                                         input logic [GL_MAX_IN-1:0] vec,
                                         input int unsigned n_in);
        logic r_and;
        logic r_or;
        logic r_xor;
        logic y;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int unsigned i = 0; i < GL_MAX_IN; i++) begin
            if (i < n_in) begin
                r_and = r_and & vec[i];
                r_or  = r_or  | vec[i];
                r_xor = r_xor ^ vec[i];
            end
        end
        case (mode)
            GL_OR:   y = r_or;
            GL_XOR:  y = r_xor;
            GL_NAND: y = ~r_and;
            GL_NOR:  y = ~r_or;
            GL_XNOR: y = ~r_xor;
            default: y = r_and;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gsc_lat_counter.sv
// Latency counter for the sweep checker WAIT state.
// Ports: clk, rst (async, active-high), load (clear to zero), en (count up),
//        tc (count has reached LAT-1).
module gsc_lat_counter #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    // LAT==0 never enters WAIT, so the terminal value only matters for LAT>=1.
    localparam logic [3:0] TERM = 4'((LAT == 0) ? 0 : LAT - 1);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table checker for an external N_IN-input gate.
// Drives every vector on stim, samples dut_y LAT cycles later and compares
// against golden_gate(mode_q, stim).
// Ports: clk, rst (async, active-high), start, mode[2:0], stim[N_IN-1:0],
//        dut_y, busy, done, pass, err_count[ERR_W-1:0] (saturating),
//        fail_vec[N_IN-1:0] (first mismatch), fail_valid.
// Build option: define GSC_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_sweep_checker
    import gate_lib_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned LAT   = 1,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    output logic [N_IN-1:0]  stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  fail_vec,
    output logic             fail_valid
);

    localparam logic [N_IN:0] LAST_VEC = {1'b0, {N_IN{1'b1}}};

    gsc_state_t       state;
    logic [2:0]       mode_q;
    logic [N_IN:0]    vec;
    logic             cnt_tc;
    logic             mismatch;
    logic             stop_now;
    logic [ERR_W-1:0] err_next;

    gsc_lat_counter #(
        .LAT (LAT)
    ) u_lat_counter (
        .clk  (clk),
        .rst  (rst),
        .load (state == GSC_APPLY),
        .en   (state == GSC_WAIT),
        .tc   (cnt_tc)
    );

    assign mismatch = (dut_y != golden_gate(mode_q, GL_MAX_IN'(stim), N_IN));
    assign err_next = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

`ifdef GSC_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= GSC_IDLE;
            mode_q     <= '0;
            vec        <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            case (state)
                GSC_IDLE, GSC_DONE: begin
                    if (start) begin
                        mode_q     <= mode;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        vec        <= '0;
                        busy       <= 1'b1;
                        state      <= GSC_APPLY;
                    end
                end
                GSC_APPLY: begin
                    stim  <= vec[N_IN-1:0];
                    state <= (LAT == 0) ? GSC_CHECK : GSC_WAIT;
                end
                GSC_WAIT: begin
                    if (cnt_tc) begin
                        state <= GSC_CHECK;
                    end
                end
                GSC_CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_vec   <= stim;
                        fail_valid <= 1'b1;
                    end
                    if ((vec == LAST_VEC) || stop_now) begin
                        state <= GSC_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= GSC_APPLY;
                    end
                end
                default: state <= GSC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker: a registered 3-input DUT
// (LAT=2, ERR_W=3) and a combinational 2-input DUT (LAT=0, ERR_W=8), each an
// emulated gate with per-vector fault injection.
module tb_gate_sweep_checker;

    localparam int S_N = 3, S_LAT = 2, S_ERRW = 3;
    localparam int C_N = 2, C_LAT = 0, C_ERRW = 8;
    localparam int LIMIT = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // sequential-DUT checker
    logic              s_start = 1'b0;
    logic [2:0]        s_mode = '0;
    logic [S_N-1:0]    s_stim;
    logic              s_dut_y;
    logic              s_busy, s_done, s_pass, s_fail_valid;
    logic [S_ERRW-1:0] s_err;
    logic [S_N-1:0]    s_fail_vec;

    // combinational-DUT checker
    logic              c_start = 1'b0;
    logic [2:0]        c_mode = '0;
    logic [C_N-1:0]    c_stim;
    logic              c_dut_y;
    logic              c_busy, c_done, c_pass, c_fail_valid;
    logic [C_ERRW-1:0] c_err;
    logic [C_N-1:0]    c_fail_vec;

    gate_sweep_checker #(.N_IN(S_N), .LAT(S_LAT), .ERR_W(S_ERRW)) u_seq (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .stim(s_stim),
        .dut_y(s_dut_y), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err), .fail_vec(s_fail_vec), .fail_valid(s_fail_valid)
    );

    gate_sweep_checker #(.N_IN(C_N), .LAT(C_LAT), .ERR_W(C_ERRW)) u_comb (
        .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .stim(c_stim),
        .dut_y(c_dut_y), .busy(c_busy), .done(c_done), .pass(c_pass),
        .err_count(c_err), .fail_vec(c_fail_vec), .fail_valid(c_fail_valid)
    );

    // Reference gate from the truth-table definition (popcount / all-ones tests).
    function automatic bit ref_gate(input int m, input int v, input int n);
        int all_ones;
        int ones;
        all_ones = (1 << n) - 1;
        ones = $countones(v);
        case (m)
            1:       return v != 0;
            2:       return (ones % 2) == 1;
            3:       return v != all_ones;
            4:       return v == 0;
            5:       return (ones % 2) == 0;
            default: return v == all_ones;
        endcase
    endfunction

    // Emulated gates under test: chosen function with per-vector output flips.
    int       s_dmode = 0;
    bit [7:0] s_flip = '0;
    int       c_dmode = 0;
    bit [3:0] c_flip = '0;
    logic [S_LAT-1:0] s_pipe = '0;

    always @(posedge clk)
        s_pipe <= {s_pipe[S_LAT-2:0], ref_gate(s_dmode, int'(s_stim), S_N) ^ s_flip[s_stim]};
    assign s_dut_y = s_pipe[S_LAT-1];
    always_comb c_dut_y = ref_gate(c_dmode, int'(c_stim), C_N) ^ c_flip[c_stim];

    // Observation mux so one sweep task serves both instances.
    int sel = 0;
    logic o_busy, o_done, o_pass, o_fail_valid;
    int   o_stim, o_err, o_fail_vec;
    always_comb begin
        if (sel == 0) begin
            o_busy = s_busy; o_done = s_done; o_pass = s_pass; o_fail_valid = s_fail_valid;
            o_stim = int'(s_stim); o_err = int'(s_err); o_fail_vec = int'(s_fail_vec);
        end else begin
            o_busy = c_busy; o_done = c_done; o_pass = c_pass; o_fail_valid = c_fail_valid;
            o_stim = int'(c_stim); o_err = int'(c_err); o_fail_vec = int'(c_fail_vec);
        end
    end

    task automatic drive(input int which, input bit st, input int m);
        if (which == 0) begin s_start = st; s_mode = 3'(m); end
        else            begin c_start = st; c_mode = 3'(m); end
    endtask

    task automatic do_sweep(input int which, input int smode, input int dmode,
                            input int flips, input bit hold, input string tag);
        int n, lat, errw, first, cnt, nvec, exp_err, exp_cycles, cycles, bad_stim;
        n    = (which == 0) ? S_N : C_N;
        lat  = (which == 0) ? S_LAT : C_LAT;
        errw = (which == 0) ? S_ERRW : C_ERRW;
        sel  = which;
        if (which == 0) begin s_dmode = dmode; s_flip = 8'(flips); end
        else            begin c_dmode = dmode; c_flip = 4'(flips); end

        first = -1;
        cnt = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (ref_gate(smode, v, n) != (ref_gate(dmode, v, n) ^ flips[v])) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
        nvec = 1 << n;
`ifdef GSC_STOP_ON_FAIL_EN
        if (first >= 0) begin nvec = first + 1; cnt = 1; end
`endif
        exp_err = (cnt > (1 << errw) - 1) ? (1 << errw) - 1 : cnt;
        exp_cycles = nvec * (lat + 2);

        @(negedge clk);
        drive(which, 1'b1, smode);
        @(negedge clk);
        drive(which, hold, smode);
        cycles = 0;
        bad_stim = 0;
        while (o_busy && cycles < LIMIT) begin
            if (cycles >= 1 && o_stim != (cycles - 1) / (lat + 2)) bad_stim++;
            // start pulses and mode changes while busy must be ignored
            drive(which, hold ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, 7));
            cycles++;
            @(negedge clk);
        end
        if (!hold) drive(which, 1'b0, smode);

        checks++; if (cycles !== exp_cycles) begin errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", tag, cycles, exp_cycles); end
        checks++; if (bad_stim !== 0) begin errors++;
            $display("FAIL %s stim_seq: got %0d bad cycles expected 0", tag, bad_stim); end
        checks++; if ({o_busy, o_done} !== 2'b01) begin errors++;
            $display("FAIL %s busy_done: got %b expected 01", tag, {o_busy, o_done}); end
        checks++; if (o_pass !== (cnt == 0)) begin errors++;
            $display("FAIL %s pass: got %b expected %b", tag, o_pass, cnt == 0); end
        checks++; if (o_err !== exp_err) begin errors++;
            $display("FAIL %s err_count: got %0d expected %0d", tag, o_err, exp_err); end
        checks++; if (o_fail_valid !== (first >= 0)) begin errors++;
            $display("FAIL %s fail_valid: got %b expected %b", tag, o_fail_valid, first >= 0); end
        checks++; if (o_fail_vec !== ((first >= 0) ? first : 0)) begin errors++;
            $display("FAIL %s fail_vec: got %0d expected %0d", tag, o_fail_vec, (first >= 0) ? first : 0); end
        checks++; if (o_stim !== nvec - 1) begin errors++;
            $display("FAIL %s final_stim: got %0d expected %0d", tag, o_stim, nvec - 1); end

        if (hold) begin
            @(negedge clk);
            checks++; if ({o_busy, o_done} !== 2'b10) begin errors++;
                $display("FAIL %s restart: got busy,done=%b expected 10", tag, {o_busy, o_done}); end
            drive(which, 1'b0, smode);
            cycles = 0;
            while (o_busy && cycles < LIMIT) begin cycles++; @(negedge clk); end
            checks++; if (o_done !== 1'b1) begin errors++;
                $display("FAIL %s restart_done: got %b expected 1", tag, o_done); end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({s_busy, s_done, s_pass, s_fail_valid, s_stim, s_err, s_fail_vec} !== '0) begin
            errors++;
            $display("FAIL reset_seq: got %b expected all zero",
                     {s_busy, s_done, s_pass, s_fail_valid, s_stim, s_err, s_fail_vec});
        end
        checks++;
        if ({c_busy, c_done, c_pass, c_fail_valid, c_stim, c_err, c_fail_vec} !== '0) begin
            errors++;
            $display("FAIL reset_comb: got %b expected all zero",
                     {c_busy, c_done, c_pass, c_fail_valid, c_stim, c_err, c_fail_vec});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_or_pass();
        do_sweep(0, 1, 1, 0, 1'b0, "or_pass");
    endtask

    task automatic test_stuck_at_0();
        // AND with the all-ones output flipped is constant 0
        do_sweep(0, 1, 0, 1 << ((1 << S_N) - 1), 1'b0, "stuck0");
    endtask

    task automatic test_comb_xor();
        do_sweep(1, 2, 2, 0, 1'b0, "comb_xor");
        do_sweep(1, 5, 5, 4'b0100, 1'b0, "comb_xnor_bad2");
    endtask

    task automatic test_saturation();
        do_sweep(0, 0, 3, 0, 1'b0, "saturate");
    endtask

    task automatic test_reserved_mode();
        do_sweep(0, 6, 0, 0, 1'b0, "mode6");
        do_sweep(1, 7, 0, 0, 1'b0, "mode7");
    endtask

    task automatic test_random();
        int which, m, d, f;
        for (int i = 0; i < 8; i++) begin
            which = $urandom_range(0, 1);
            m = $urandom_range(0, 7);
            d = ($urandom_range(0, 1) == 1) ? m : $urandom_range(0, 7);
            f = $urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255);
            do_sweep(which, m, d, f, 1'b0, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid_sweep();
        int k;
        sel = 0;
        s_dmode = 4;
        s_flip = 8'h0F;
        @(negedge clk);
        drive(0, 1'b1, 4);
        @(negedge clk);
        drive(0, 1'b0, 4);
        k = 0;
        while (int'(s_stim) != 2 && k < LIMIT) begin k++; @(negedge clk); end
        checks++; if (int'(s_stim) !== 2) begin errors++;
            $display("FAIL rst_mid reach_vec2: got stim %0d expected 2", s_stim); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s_busy, s_done, s_pass, s_fail_valid, s_stim, s_err, s_fail_vec} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: got %b expected all zero",
                     {s_busy, s_done, s_pass, s_fail_valid, s_stim, s_err, s_fail_vec});
        end
        @(negedge clk);
        rst = 1'b0;
        do_sweep(0, 4, 4, 8'h20, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        do_sweep(0, 2, 2, 8'h40, 1'b1, "b2b_seq");
        do_sweep(1, 1, 1, 0, 1'b1, "b2b_comb");
    endtask

    initial begin
        test_reset();
        test_or_pass();
        test_stuck_at_0();
        test_comb_xor();
        test_saturation();
        test_reserved_mode();
        test_random();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Synthesizable exhaustive truth-table checker for an external N-input combinational or registered logic gate.
- Drives every input vector 0 to 2^N_IN-1 onto the DUT and samples the DUT output after a programmable latency.
- Compares each sample against an internal golden gate model selected by mode.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits beside gate-level DUTs in the gate library as an on-chip self-test harness.

Parameters:
- N_IN, 2, number of gate inputs (1..16).
- LAT, 1, DUT latency in clock cycles from stim change to valid dut_y (0..15; 0 = combinational DUT).
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- mode  input  3  golden function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved (treated as AND).
- stim  output  N_IN  registered input vector driven to the DUT.
- dut_y  input  1  DUT output.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until next start.
- pass  output  1  valid while done; 1 iff err_count==0.
- err_count  output  ERR_W  mismatch count, saturating at all-ones.
- fail_vec  output  N_IN  first mismatching vector.
- fail_valid  output  1  fail_vec holds a captured vector.

Behaviour:
- Reset (asynchronous, any state): state IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0.
- Reset during a sweep aborts it with no partial results retained.
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE with start=1:
  - latch mode into mode_q;
  - clear err_count, fail_vec, fail_valid, done, pass;
  - vec=0, busy=1;
  - go to APPLY.
- APPLY: stim<=vec; wait counter<=0. If LAT==0 go to CHECK, else go to WAIT.
- WAIT: counter increments each cycle. When counter==LAT-1, go to CHECK. The stim register is stable throughout.
- CHECK (exactly LAT cycles after stim is updated):
  - compare dut_y against golden(mode_q, stim);
  - on mismatch: increment err_count, saturating at all-ones; if fail_valid==0, capture fail_vec=stim and set fail_valid=1;
  - if vec==2^N_IN-1, go to DONE; otherwise vec++ and go to APPLY.
- Each vector takes LAT+2 cycles (APPLY, LAT waits, CHECK). busy is high for 2^N_IN*(LAT+2) cycles.
- DONE: busy=0, done=1, pass=(err_count==0). stim holds its last vector. Outputs are held until start.
- start while busy: ignored. mode changes while busy: ignored; only mode_q is used.
- start held continuously: a new sweep begins on the first cycle spent in DONE.
- vec counter is N_IN+1 bits wide to avoid wrap at N_IN=16. stim takes the low N_IN bits.
- Golden model: reduction operator over stim. NAND/NOR/XNOR are inversions of AND/OR/XOR.
- N_IN=1: AND/OR return stim; XOR returns stim; NAND/NOR/XNOR return ~stim.

Optional Feature:
- Macro: GSC_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK transitions directly to DONE. err_count is 1, pass=0, and fail_vec is the failing vector.
- Undefined: the sweep always completes over all vectors.

Decomposition:
- Shared package gate_lib_pkg:
  - mode encoding constants GL_AND..GL_XNOR;
  - typedef for the state enum;
  - function golden_gate(mode, vec), reused by other gate-library blocks.
- One sub-module: gsc_lat_counter, the WAIT-state latency counter with load/terminal-count. This keeps the FSM free of counter arithmetic.

Test Plan:
- N_IN=2, LAT=1, mode=1, correct OR DUT, pulse start -> stim sequence 0,1,2,3; busy for 12 cycles; done=1, pass=1, err_count=0, fail_valid=0.
- N_IN=2, LAT=1, mode=1, DUT stuck-at-0 -> err_count=3, fail_vec=2'b01, fail_valid=1, pass=0.
- N_IN=3, LAT=0, mode=2, combinational XOR DUT -> 8 vectors, busy for 16 cycles, pass=1. Change mode to 0 mid-sweep -> result unchanged.
- N_IN=3, ERR_W=2, mode=0, DUT outputs ~AND -> 8 mismatches; err_count saturates at 3; fail_vec=0.
- Assert rst during vector 2 of a sweep -> all outputs return to reset values immediately. A new start runs a clean full sweep.
- With GSC_STOP_ON_FAIL_EN, N_IN=2, mode=3, DUT wrong only at vec=2 -> done after the third CHECK; err_count=1, fail_vec=2'b10, stim=2'b10.
